// File: rtl/sram_rd_streamer_if.sv
// sram_rd_streamer_if: SRAM read port plus valid/ready output stream of sram_rd_streamer.
interface sram_rd_streamer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_val;
    logic                  out_rdy;
    modport master_mp (output rd_en, rd_addr, out_data, out_val, input rd_data, out_rdy);
    modport slave_mp (input rd_en, rd_addr, out_data, out_val, output rd_data, out_rdy);
endinterface

// File: rtl/sram_rd_streamer.sv
// sram_rd_streamer: reads len words from base and streams them out through a small FIFO.
// Optional back-pressure counter enabled by macro SRAM_RD_STREAMER_STALL_CNT_EN.
module sram_rd_streamer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           stall_cnt_o,
    sram_rd_streamer_if.master_mp bus_io
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;
    state_e                state_q;
    logic                  busy_q, done_q, rd_en_q, in_flight_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, base_q;
    logic [ADDR_WIDTH:0]   len_q, issued_q, popped_q, issued_d, popped_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           cnt_q, cnt_d;
    logic                  out_val, push, pop, room, issue;

    assign out_val  = cnt_q != '0;
    assign push     = in_flight_q;
    assign pop      = out_val && bus_io.out_rdy;
    assign cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    // Room is judged on next-cycle occupancy plus the read whose data lands next cycle.
    assign room     = ({1'b0, cnt_d} + (PW+2)'(rd_en_q)) < (PW+2)'(FIFO_DEPTH);
    assign issue    = state_q == RUN && issued_q < len_q && room;
    assign issued_d = issued_q + (ADDR_WIDTH+1)'(issue);
    assign popped_d = popped_q + (ADDR_WIDTH+1)'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            in_flight_q <= 1'b0;
            rd_addr_q   <= '0;
            base_q      <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
        end else begin
            in_flight_q <= rd_en_q;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            popped_q    <= popped_d;
            case (state_q)
                IDLE: if (start_i) begin
                    base_q   <= base_addr_i;
                    len_q    <= len_i;
                    popped_q <= '0;
                    issued_q <= '0;
                    if (len_i != '0) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= base_addr_i;
                        issued_q  <= (ADDR_WIDTH+1)'(1);
                    end else begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= base_q + issued_q[ADDR_WIDTH-1:0];
                    end
                    issued_q <= issued_d;
                    if (issued_d == len_q) state_q <= DRAIN;
                end
                DRAIN: if (popped_d == len_q) begin
                    state_q <= FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                FIN: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus_io.rd_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

`ifdef SRAM_RD_STREAMER_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start_i)) stall_q <= '0;
        else if (out_val && !bus_io.out_rdy && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end
    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign bus_io.rd_en    = rd_en_q;
    assign bus_io.rd_addr  = rd_addr_q;
    assign bus_io.out_val  = out_val;
    assign bus_io.out_data = out_val ? mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_sram_rd_streamer.sv
// tb_sram_rd_streamer: directed and randomized transfers checked against a queue-based model.
module tb_sram_rd_streamer;
    localparam int AW = 10, DW = 8, DEPTH = 4, MSZ = 1 << AW;
`ifdef SRAM_RD_STREAMER_STALL_CNT_EN
    localparam int EXP_STALL = 10;
`else
    localparam int EXP_STALL = 0;
`endif
    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW:0]   len = '0;
    logic          busy, done;
    logic [15:0]   stall_cnt;
    logic [DW-1:0] mem [MSZ];
    int            n_cmp = 0, n_err = 0, cyc = 0;
    int            n_rd, n_pop, n_done, first_rd, last_rd, first_val, done_cyc, start_cyc;
    bit            busy_seen;
    int            exp_addr[$], exp_data[$];

    sram_rd_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sram_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .len_i(len),
        .busy_o(busy), .done_o(done), .stall_cnt_o(stall_cnt), .bus_io(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                chk("rd_addr", 32'(bus.rd_addr), exp_addr.size() != 0 ? exp_addr.pop_front() : 32'hDEAD);
                chk("fifo_bound", 32'(n_rd - n_pop <= DEPTH), 1);
            end
            if (bus.out_val && first_val < 0) first_val = cyc;
            if (bus.out_val && bus.out_rdy) begin
                n_pop++;
                chk("out_data", 32'(bus.out_data), exp_data.size() != 0 ? exp_data.pop_front() : 32'hDEAD);
            end
            if (busy) busy_seen = 1'b1;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_model();
        n_rd = 0; n_pop = 0; n_done = 0; first_rd = -1; last_rd = -1; first_val = -1;
        done_cyc = -1; busy_seen = 1'b0;
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic load(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back((b + i) % MSZ);
            exp_data.push_back(int'(mem[(b + i) % MSZ]));
        end
    endtask

    task automatic go(input int b, input int l);
        tick(1);
        base = AW'(b); len = (AW+1)'(l); start = 1'b1; start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit rnd, input bit restart);
        for (int k = 0; k < budget && n_done == 0; k++) begin
            tick(1);
            if (rnd) bus.out_rdy = 1'($urandom_range(0, 1));
            start = restart && k == 2;
            if (start) begin
                base = AW'($urandom);
                len = (AW+1)'(3);
            end
        end
        start = 1'b0;
        bus.out_rdy = 1'b1;
        chk("done_in_time", 32'(n_done != 0), 1);
        tick(3);
        chk("one_done", n_done, 1);
        chk("data_left", exp_data.size(), 0);
        chk("addr_left", exp_addr.size(), 0);
        chk("busy_after", 32'(busy), 0);
    endtask

    task automatic xfer(input int b, input int l, input bit rnd, input bit restart);
        reset_model();
        load(b, l);
        go(b, l);
        wait_done(4 * l + 40, rnd, restart);
        if (l > 0) begin
            chk("first_val_lat", first_val - first_rd, 2);
            chk("rd_count", n_rd, l);
            if (!rnd) chk("rd_back_to_back", last_rd - first_rd, l - 1);
        end else begin
            chk("len0_busy", 32'(busy_seen), 0);
            chk("len0_reads", n_rd, 0);
            chk("len0_val", first_val, -1);
            chk("len0_done_lat", done_cyc - start_cyc, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < MSZ; i++) mem[i] = DW'($urandom);
        bus.out_rdy = 1'b1;
        reset_model();
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd_en", 32'(bus.rd_en), 0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("rst_out_val", 32'(bus.out_val), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        rst = 1'b0;
        xfer(32'h010, 4, 1'b0, 1'b0);
        xfer(32'h3FE, 4, 1'b0, 1'b0);
        xfer(32'h055, 0, 1'b0, 1'b0);
        reset_model();
        load(32'h200, 8);
        go(32'h200, 8);
        for (int k = 0; k < 20 && !bus.out_val; k++) tick(1);
        chk("val_before_stall", 32'(bus.out_val), 1);
        bus.out_rdy = 1'b0;
        tick(10);
        chk("stall_reads_le_depth", 32'(n_rd <= DEPTH), 1);
        chk("stall_cnt", 32'(stall_cnt), EXP_STALL);
        bus.out_rdy = 1'b1;
        wait_done(60, 1'b0, 1'b0);
        chk("stall_rd_count", n_rd, 8);
        reset_model();
        load(32'h100, 16);
        go(32'h100, 16);
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_rd_en", 32'(bus.rd_en), 0);
        chk("mid_rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("mid_rst_out_val", 32'(bus.out_val), 0);
        chk("mid_rst_out_data", 32'(bus.out_data), 0);
        chk("mid_rst_stall", 32'(stall_cnt), 0);
        rst = 1'b0;
        reset_model();
        tick(4);
        chk("no_done_after_rst", n_done, 0);
        chk("no_rd_after_rst", n_rd, 0);
        chk("no_val_after_rst", first_val, -1);
        xfer(0, 2, 1'b0, 1'b0);
        xfer(32'h123, 6, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) xfer(int'($urandom_range(0, MSZ - 1)), int'($urandom_range(1, 40)), 1'b1, 1'b0);
        xfer(int'($urandom_range(MSZ - 8, MSZ - 1)), 20, 1'b1, 1'b0);
        xfer(int'($urandom_range(0, MSZ - 1)), MSZ, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
